mgt_01_mul_unit: RTL and testbench



---
 rtl/mgt_01_mul_unit.sv | 140 ++++++++++++++
 tb/tb_mgt_01_mul_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mgt_01_mul_unit.sv
// Sequential radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One operation in flight: capture, XLEN add/shift iterations, sign fix-up.
module mgt_01_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clk_en_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] multiplicand_i,
  input  logic [XLEN-1:0] multiplier_i,
  input  logic [1:0]      operation_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic            fu_state_o
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    MUL_    = 2'd0,
    MULH_   = 2'd1,
    MULHSU_ = 2'd2,
    MULHU_  = 2'd3
  } mul_ops_e;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    FINISH   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  mul_ops_e          op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_d;
  logic              valid_d;

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  mul_ops_e               op_in;
  logic                   rs1_signed, rs2_signed;
  logic                   rs1_neg, rs2_neg;
  logic [XLEN:0]          sum;
  logic [2*XLEN-1:0]      prod_fix;

  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic is_signed);
    if (is_signed && (v < 0)) begin
      return $unsigned(-v);
    end
    return $unsigned(v);
  endfunction

  function automatic logic [2*XLEN-1:0] apply_sign(input logic [2*XLEN-1:0] v,
                                                   input logic neg);
    return neg ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  assign rs1_s      = multiplicand_i;
  assign rs2_s      = multiplier_i;
  assign op_in      = mul_ops_e'(operation_i);
  assign rs1_signed = (op_in != MULHU_);
  assign rs2_signed = (op_in == MUL_) || (op_in == MULH_);
  assign rs1_neg    = rs1_signed && (rs1_s < 0);
  assign rs2_neg    = rs2_signed && (rs2_s < 0);

  // Upper half accumulates the multiplicand; the multiplier shifts out of the lower half.
  assign sum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_fix = apply_sign(prod_q, neg_q);

  assign fu_state_o = (state_q == IDLE) ? FREE : BUSY;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_o;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          mcand_d = magnitude(rs1_s, rs1_signed);
          prod_d  = {{XLEN{1'b0}}, magnitude(rs2_s, rs2_signed)};
          op_d    = op_in;
          neg_d   = rs1_neg ^ rs2_neg;
          cnt_d   = '0;
          state_d = MULTIPLY;
        end
      end
      MULTIPLY: begin
        prod_d = {sum, prod_q[XLEN-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        result_d = (op_q == MUL_) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over the clock enable and drops any operation in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      op_q     <= MUL_;
      neg_q    <= 1'b0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else if (clk_en_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_o <= result_d;
      valid_o  <= valid_d;
    end
  end

endmodule

// File: tb/tb_mgt_01_mul_unit.sv
// Self-checking bench for mgt_01_mul_unit: vector table, randomized ops against
// a 64-bit arithmetic model, and hand-written handshake/enable/reset sequences.
module tb_mgt_01_mul_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  op = '0;
  logic [31:0] result;
  logic        valid_o;
  logic        fu_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  mgt_01_mul_unit #(.XLEN(32)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clk_en_i      (clk_en),
    .valid_i       (valid),
    .multiplicand_i(a),
    .multiplier_i  (b),
    .operation_i   (op),
    .result_o      (result),
    .valid_o       (valid_o),
    .fu_state_o    (fu_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit multiply of sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    longint      sx, sy, p;
    logic [63:0] pu;
    sx = (o != 2'd3 && x[31]) ? {32'hFFFFFFFF, x} : {32'h0, x};
    sy = (o <= 2'd1 && y[31]) ? {32'hFFFFFFFF, y} : {32'h0, y};
    p  = sx * sy;
    pu = p;
    return (o == 2'd0) ? pu[31:0] : pu[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h80000000;
      3:       return 32'hFFFFFFFF;
      4:       return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  // Called #1 after a rising edge; returns with the result cycle visible.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    op = o; a = x; b = y; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    int          late;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    vecs[0] = '{2'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[5] = '{2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[6] = '{2'd1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[7] = '{2'd3, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[8] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_fu_state", 32'(fu_state), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd34);
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse", i), 32'(valid_o), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = pick();
      ry = pick();
      do_op(ro, rx, ry, r, lat);
      check($sformatf("rand%0d_op%0d_%08h_%08h", i, ro, rx, ry), r, ref_mul(ro, rx, ry));
      @(posedge clk); #1;
    end

    // valid_i held high with shifting operands while busy, then back-to-back start.
    op = 2'd0; a = 32'd7; b = 32'hFFFFFFFD; valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    check("busy_fu_state", 32'(fu_state), 32'd1);
    while (!valid_o && lat < 200) begin
      a = $urandom(); b = $urandom(); op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      lat++;
    end
    check("busy_result", result, 32'hFFFFFFEB);
    check("busy_latency", 32'(lat), 32'd34);
    check("busy_free_at_valid", 32'(fu_state), 32'd0);
    op = 2'd3; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1;
    check("b2b_pulse", 32'(valid_o), 32'd0);
    check("b2b_busy", 32'(fu_state), 32'd1);
    check("b2b_hold_first", result, 32'hFFFFFFEB);
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_result", result, 32'hFFFFFFFE);
    check("b2b_latency", 32'(lat), 32'd34);
    @(posedge clk); #1;

    // Five disabled edges in the middle of MULTIPLY.
    op = 2'd1; a = 32'h80000000; b = 32'h80000000; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1;
    while (!valid_o && lat < 200) begin
      if (lat == 10) clk_en = 1'b0;
      if (lat == 15) clk_en = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    clk_en = 1'b1;
    check("gap_result", result, 32'h40000000);
    check("gap_latency", 32'(lat), 32'd39);

    // valid_o is stretched while the enable is low.
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stretch%0d_valid", i), 32'(valid_o), 32'd1);
    end
    check("stretch_result", result, 32'h40000000);
    clk_en = 1'b1;
    @(posedge clk); #1;
    check("stretch_release", 32'(valid_o), 32'd0);

    // Reset (with enable low) aborts an operation at iteration 10.
    op = 2'd3; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0; clk_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; clk_en = 1'b1;
    check("abort_fu_state", 32'(fu_state), 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_valid", 32'(valid_o), 32'd0);
    late = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) late++;
    end
    check("abort_no_late_valid", 32'(late), 32'd0);

    do_op(2'd3, 32'd3, 32'd5, r, lat);
    check("post_mulhu_result", r, 32'h0);
    check("post_mulhu_valid", 32'(valid_o), 32'd1);
    check("post_mulhu_latency", 32'(lat), 32'd34);
    @(posedge clk); #1;
    do_op(2'd0, 32'd3, 32'd5, r, lat);
    check("post_mul_result", r, 32'h0000000F);
    check("post_mul_latency", 32'(lat), 32'd34);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
